multdiv_writeback: RTL and testbench

Iterative signed 32-bit multiply/divide unit that sits directly upstream of the register file write port. It accepts one MULT or DIV operation at a time and computes it over a fixed 33-cycle latency. It then presents the result as a single-cycle write-port transaction (enable, register index, data) for the regfile. On overflow or divide-by-zero it redirects the write to the status register with an exception code.

---
 rtl/multdiv_writeback.sv | 144 ++++++++++++++
 tb/tb_multdiv_writeback.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/multdiv_writeback.sv
// Iterative signed 32-bit multiply/divide unit feeding the regfile write port.
// Shift-add multiply / restoring divide on magnitudes, sign fixed on the final iteration.
module multdiv_writeback #(
  parameter logic [4:0]  STATUS_REG    = 5'd30,
  parameter logic [31:0] MULT_EXC_CODE = 32'd4,
  parameter logic [31:0] DIV_EXC_CODE  = 32'd5
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic [4:0]  ctrl_destReg,
  output logic        ctrl_busy,
  output logic        data_resultRDY,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        wb_writeEnable,
  output logic [4:0]  wb_writeReg,
  output logic [31:0] wb_data
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state, w_state_next;
  logic [4:0]  r_cnt;
  logic        r_is_mult, r_neg, r_div0;
  logic [4:0]  r_dest;
  logic [31:0] r_opa;     // multiplier (shifts right) or dividend/quotient (shifts left)
  logic [31:0] r_mag_b;
  logic [63:0] r_mcand;
  logic [63:0] r_acc;
  logic [32:0] r_rem;
  logic        r_rdy, r_exc, r_we;
  logic [31:0] r_result, r_wdata;
  logic [4:0]  r_wreg;

  logic        w_accept, w_last;
  logic [31:0] w_mag_a, w_mag_b;
  logic [63:0] w_acc_next, w_prod;
  logic [32:0] w_shift, w_rem_next;
  logic [33:0] w_diff;
  logic [31:0] w_quo_next, w_quo_s, w_res;
  logic        w_mult_ovf, w_exc;

  assign w_accept = (r_state != S_RUN) && (ctrl_MULT || ctrl_DIV);
  assign w_last   = (r_state == S_RUN) && (r_cnt == 5'd31);
  assign w_mag_a  = data_operandA[31] ? -data_operandA : data_operandA;
  assign w_mag_b  = data_operandB[31] ? -data_operandB : data_operandB;

  assign w_acc_next = r_acc + (r_opa[0] ? r_mcand : 64'd0);
  assign w_shift    = {r_rem[31:0], r_opa[31]};
  assign w_diff     = {1'b0, w_shift} - {2'b00, r_mag_b};
  assign w_rem_next = w_diff[33] ? w_shift : w_diff[32:0];
  assign w_quo_next = {r_opa[30:0], ~w_diff[33]};

  // Final iteration values, sign-corrected and truncated to 32 bits.
  assign w_prod     = r_neg ? -w_acc_next : w_acc_next;
  assign w_quo_s    = r_neg ? -w_quo_next : w_quo_next;
  assign w_mult_ovf = (w_prod[63:32] != {32{w_prod[31]}});
  assign w_res      = r_is_mult ? w_prod[31:0] : (r_div0 ? 32'd0 : w_quo_s);
  assign w_exc      = r_is_mult ? w_mult_ovf : r_div0;

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) r_state <= S_IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_RUN;
      S_RUN:   if (w_last)   w_state_next = S_DONE;
      S_DONE:  w_state_next = w_accept ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      r_cnt     <= '0;
      r_is_mult <= 1'b0;
      r_neg     <= 1'b0;
      r_div0    <= 1'b0;
      r_dest    <= '0;
      r_opa     <= '0;
      r_mag_b   <= '0;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_rdy     <= 1'b0;
      r_exc     <= 1'b0;
      r_result  <= '0;
      r_we      <= 1'b0;
      r_wreg    <= '0;
      r_wdata   <= '0;
    end else begin
      r_rdy   <= 1'b0;
      r_we    <= 1'b0;
      r_wreg  <= '0;
      r_wdata <= '0;
      if (w_accept) begin
        r_cnt     <= '0;
        r_is_mult <= ctrl_MULT;
        r_neg     <= data_operandA[31] ^ data_operandB[31];
        r_div0    <= (data_operandB == 32'd0);
        r_dest    <= ctrl_destReg;
        r_opa     <= ctrl_MULT ? w_mag_b : w_mag_a;
        r_mag_b   <= w_mag_b;
        r_mcand   <= {32'd0, w_mag_a};
        r_acc     <= '0;
        r_rem     <= '0;
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + 5'd1;
        if (r_is_mult) begin
          r_acc   <= w_acc_next;
          r_mcand <= r_mcand << 1;
          r_opa   <= r_opa >> 1;
        end else begin
          r_rem <= w_rem_next;
          r_opa <= w_quo_next;
        end
        if (w_last) begin
          r_rdy    <= 1'b1;
          r_we     <= 1'b1;
          r_result <= w_res;
          r_exc    <= w_exc;
          r_wreg   <= w_exc ? STATUS_REG : r_dest;
          r_wdata  <= w_exc ? (r_is_mult ? MULT_EXC_CODE : DIV_EXC_CODE) : w_res;
        end
      end
    end
  end

  assign ctrl_busy      = (r_state == S_RUN);
  assign data_resultRDY = r_rdy;
  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign wb_writeEnable = r_we;
  assign wb_writeReg    = r_wreg;
  assign wb_data        = r_wdata;

endmodule

// File: tb/tb_multdiv_writeback.sv
// Bench for multdiv_writeback: directed cases from the test plan plus random ops
// checked against a 64-bit arithmetic reference model.
module tb_multdiv_writeback;
  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [4:0]  ctrl_destReg = '0;
  logic        ctrl_busy, data_resultRDY, data_exception, wb_writeEnable;
  logic [31:0] data_result, wb_data;
  logic [4:0]  wb_writeReg;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] e_res, e_wdata;
  logic        e_exc;
  logic [4:0]  e_wreg;
  time         t_issue, t_rdy, t_prev;

  always #5 clock = ~clock;

  multdiv_writeback dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB), .ctrl_destReg(ctrl_destReg),
    .ctrl_busy(ctrl_busy), .data_resultRDY(data_resultRDY), .data_result(data_result),
    .data_exception(data_exception), .wb_writeEnable(wb_writeEnable),
    .wb_writeReg(wb_writeReg), .wb_data(wb_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint sa, sb, p, q;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    if (m) begin
      p = sa * sb;
      r = p[31:0];
      e = (p != longint'(signed'(p[31:0])));
    end else if (sb == 0) begin
      r = 32'd0;
      e = 1'b1;
    end else begin
      q = sa / sb;
      r = q[31:0];
      e = 1'b0;
    end
  endfunction

  // Called at a negedge; start is accepted on the following rising edge.
  task automatic issue(input bit m, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
    model(m, a, b, e_res, e_exc);
    e_wreg  = e_exc ? 5'd30 : d;
    e_wdata = e_exc ? (m ? 32'd4 : 32'd5) : e_res;
    ctrl_MULT = m; ctrl_DIV = !m;
    data_operandA = a; data_operandB = b; ctrl_destReg = d;
    t_issue = $time;
    @(negedge clock);
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom; ctrl_destReg = 5'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    bit bad = 0;
    while (data_resultRDY !== 1'b1 && n < 40) begin
      if (ctrl_busy !== 1'b1 || wb_writeEnable !== 1'b0 || wb_writeReg !== 5'd0 || wb_data !== 32'd0)
        bad = 1;
      @(negedge clock);
      n++;
    end
    t_rdy = $time;
    check({tag, " run_quiet"}, 32'(bad), 32'd0);
    check({tag, " latency"}, 32'((t_rdy - t_issue) / 10), 32'd33);
    check({tag, " rdy"}, 32'(data_resultRDY), 32'd1);
    check({tag, " we"}, 32'(wb_writeEnable), 32'd1);
    check({tag, " result"}, data_result, e_res);
    check({tag, " exc"}, 32'(data_exception), 32'(e_exc));
    check({tag, " wreg"}, 32'(wb_writeReg), 32'(e_wreg));
    check({tag, " wdata"}, wb_data, e_wdata);
  endtask

  task automatic after_done(input string tag);
    @(negedge clock);
    check({tag, " rdy_drop"}, 32'(data_resultRDY), 32'd0);
    check({tag, " we_drop"}, 32'(wb_writeEnable), 32'd0);
    check({tag, " wb_zero"}, {27'd0, wb_writeReg} | wb_data, 32'd0);
    check({tag, " idle"}, 32'(ctrl_busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, 32'(ctrl_busy), 32'd0);
    check({tag, " rdy"}, 32'(data_resultRDY), 32'd0);
    check({tag, " result"}, data_result, 32'd0);
    check({tag, " exc"}, 32'(data_exception), 32'd0);
    check({tag, " we"}, 32'(wb_writeEnable), 32'd0);
    check({tag, " wreg"}, 32'(wb_writeReg), 32'd0);
    check({tag, " wdata"}, wb_data, 32'd0);
  endtask

  initial begin
    bit bad;
    logic [31:0] a, b;
    bit m;
    int k;

    #1 ctrl_reset = 1'b1;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clock);
    ctrl_reset = 1'b0;
    @(negedge clock);

    issue(1'b1, 32'd7, 32'hFFFF_FFFA, 5'd3);
    wait_done("mul_7x-6");
    check("mul_7x-6 const", data_result, 32'hFFFF_FFD6);
    after_done("mul_7x-6");

    issue(1'b1, 32'h0001_0000, 32'h0001_0000, 5'd5);
    wait_done("mul_ovf");
    after_done("mul_ovf");

    issue(1'b0, 32'hFFFF_FFF9, 32'd2, 5'd8);
    wait_done("div_-7/2");
    check("div_-7/2 const", data_result, 32'hFFFF_FFFD);
    after_done("div_-7/2");

    issue(1'b0, 32'd9, 32'd0, 5'd8);
    wait_done("div_by0");
    after_done("div_by0");

    issue(1'b1, 32'd11, 32'd13, 5'd0);
    wait_done("mul_r0");
    after_done("mul_r0");

    // Wrapping divide with a start pulse injected mid-run that must be dropped.
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    repeat (4) @(negedge clock);
    ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'd3;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    check("midrun busy", 32'(ctrl_busy), 32'd1);
    wait_done("div_wrap");
    check("div_wrap const", data_result, 32'h8000_0000);
    after_done("div_wrap");

    issue(1'b1, 32'd3, 32'd4, 5'd7);
    wait_done("b2b_first");
    t_prev = t_rdy;
    issue(1'b1, 32'd5, 32'd5, 5'd9);
    wait_done("b2b_second");
    check("b2b spacing", 32'((t_rdy - t_prev) / 10), 32'd33);
    check("b2b const", data_result, 32'd25);
    after_done("b2b_second");

    issue(1'b1, 32'd100, 32'd3, 5'd4);
    repeat (9) @(negedge clock);
    #2 ctrl_reset = 1'b1;
    #1 check_all_zero("midrun_reset");
    @(negedge clock);
    ctrl_reset = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY !== 1'b0 || wb_writeEnable !== 1'b0 || ctrl_busy !== 1'b0) bad = 1;
    end
    check("aborted_op silent", 32'(bad), 32'd0);
    issue(1'b1, 32'd2, 32'd2, 5'd6);
    wait_done("mul_2x2");
    after_done("mul_2x2");

    for (int i = 0; i < 24; i++) begin
      m = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      k = int'($urandom_range(0, 4));
      if (k == 0) b = 32'($urandom_range(0, 16)) - 32'd8;
      if (k == 1) a = 32'($urandom_range(0, 2000)) - 32'd1000;
      if (k == 2) b = 32'd0;
      if (k == 3) a = 32'h8000_0000;
      issue(m, a, b, 5'($urandom));
      wait_done($sformatf("rand%0d", i));
      after_done($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
